// File: rtl/stream_sink.sv
// Consumer end of a valid/ready stream: drives ready with optional LFSR backpressure,
// checks a programmed number of beats against an incrementing sequence, flags protocol errors.
module stream_sink #(
   parameter int          WIDTH   = 8,
   parameter int          COUNT_W = 16,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [WIDTH-1:0]   i_data,
   input  logic               i_vld,
   output logic               o_rdy,
   input  logic               i_start,
   input  logic [COUNT_W-1:0] i_len,
   input  logic [WIDTH-1:0]   i_expect,
   input  logic               i_stall_en,
   output logic               o_busy,
   output logic               o_done,
   output logic [COUNT_W-1:0] o_beats,
   output logic               o_err,
   output logic [COUNT_W-1:0] o_err_idx,
   output logic [WIDTH-1:0]   o_err_data,
   output logic [WIDTH-1:0]   o_err_exp,
   output logic               o_proto_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               rdy_nxt;

   logic [COUNT_W-1:0] len_q;
   logic [WIDTH-1:0]   expect_q;
   logic [15:0]        lfsr;
   logic               lfsr_fb;
   logic               stalled_q;
   logic [WIDTH-1:0]   data_q;

   logic               in_run;
   logic               xfer;
   logic               last_xfer;
   logic               mismatch;
   logic               proto_viol;

   // A beat coinciding with i_start is consumed on the wire but ignored here.
   assign in_run     = (state == S_RUN);
   assign xfer       = in_run && i_vld && o_rdy && !i_start;
   assign last_xfer  = xfer && ((o_beats + COUNT_W'(1)) == len_q);
   assign mismatch   = xfer && (i_data != expect_q);
   assign proto_viol = in_run && stalled_q && (!i_vld || (i_data != data_q));

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      rdy_nxt   = 1'b0;
      if (i_start) begin
         state_nxt = (i_len == '0) ? S_DONE : S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               if (last_xfer) state_nxt = S_DONE;
               else           rdy_nxt   = !i_stall_en || lfsr[0];
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state  <= S_IDLE;
         o_rdy  <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         lfsr   <= SEED;
      end else begin
         state  <= state_nxt;
         o_rdy  <= rdy_nxt;
         o_busy <= (state_nxt == S_RUN);
         o_done <= (state_nxt == S_DONE);
         lfsr   <= {lfsr_fb, lfsr[15:1]};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         len_q       <= '0;
         expect_q    <= '0;
         o_beats     <= '0;
         o_err       <= 1'b0;
         o_err_idx   <= '0;
         o_err_data  <= '0;
         o_err_exp   <= '0;
         o_proto_err <= 1'b0;
         stalled_q   <= 1'b0;
         data_q      <= '0;
      end else if (i_start) begin
         len_q       <= i_len;
         expect_q    <= i_expect;
         o_beats     <= '0;
         o_err       <= 1'b0;
         o_err_idx   <= '0;
         o_err_data  <= '0;
         o_err_exp   <= '0;
         o_proto_err <= 1'b0;
         stalled_q   <= 1'b0;
         data_q      <= i_data;
      end else begin
         stalled_q <= in_run && i_vld && !o_rdy;
         data_q    <= i_data;
         if (xfer) begin
            o_beats  <= o_beats + COUNT_W'(1);
            expect_q <= expect_q + WIDTH'(1);
         end
         // Only the first mismatch of a run is recorded.
         if (mismatch && !o_err) begin
            o_err      <= 1'b1;
            o_err_idx  <= o_beats;
            o_err_data <= i_data;
            o_err_exp  <= expect_q;
         end
         if (proto_viol) o_proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_sink.sv
// Self-checking bench for stream_sink: scoreboard of per-beat status plus a
// cycle-level model of ready/busy/done driven by an LFSR reference.
module tb_stream_sink;

   localparam int          WIDTH   = 8;
   localparam int          COUNT_W = 16;
   localparam logic [15:0] SEED    = 16'hACE1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [WIDTH-1:0]   data = '0;
   logic               vld = 1'b0;
   logic               start = 1'b0;
   logic [COUNT_W-1:0] len_in = '0;
   logic [WIDTH-1:0]   exp_in = '0;
   logic               stall_en = 1'b0;

   logic               o_rdy, o_busy, o_done, o_err, o_proto_err;
   logic [COUNT_W-1:0] o_beats, o_err_idx;
   logic [WIDTH-1:0]   o_err_data, o_err_exp;

   stream_sink #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .SEED(SEED)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_data      (data),
      .i_vld       (vld),
      .o_rdy       (o_rdy),
      .i_start     (start),
      .i_len       (len_in),
      .i_expect    (exp_in),
      .i_stall_en  (stall_en),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_beats     (o_beats),
      .o_err       (o_err),
      .o_err_idx   (o_err_idx),
      .o_err_data  (o_err_data),
      .o_err_exp   (o_err_exp),
      .o_proto_err (o_proto_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected status after each accepted beat.
   typedef struct packed {
      logic [15:0] beats;
      logic        err;
      logic [15:0] idx;
      logic [7:0]  edata;
      logic [7:0]  eexp;
   } resp_t;

   resp_t sb_q[$];
   logic  sb_en = 1'b1;

   // Push-side reference: expected value of beat i is first + i modulo 256.
   logic [7:0]  p_exp0 = '0;
   int          p_cnt  = 0;
   logic        p_err  = 1'b0;
   logic [15:0] p_idx  = '0;
   logic [7:0]  p_edata = '0;
   logic [7:0]  p_eexp  = '0;

   task automatic push_beat(input logic [7:0] d);
      logic [7:0] want;
      resp_t r;
      want = p_exp0 + p_cnt[7:0];
      if (d != want && !p_err) begin
         p_err   = 1'b1;
         p_idx   = p_cnt[15:0];
         p_edata = d;
         p_eexp  = want;
      end
      p_cnt++;
      r = '{beats: p_cnt[15:0], err: p_err, idx: p_idx, edata: p_edata, eexp: p_eexp};
      sb_q.push_back(r);
   endtask

   // Monitor: every accepted beat pops one expected status record.
   always @(posedge clk) begin
      if (rst_n && sb_en && vld && o_rdy && !start) begin
         resp_t got;
         resp_t want;
         #1;
         check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            want = sb_q.pop_front();
            got  = '{beats: o_beats, err: o_err, idx: o_err_idx, edata: o_err_data, eexp: o_err_exp};
            check("beat_status", 64'(got), 64'(want));
         end
      end
   end

   // Cycle model of the handshake side: run/done flags, beat count and LFSR-driven ready.
   logic [15:0] m_lfsr = SEED;
   logic        m_run  = 1'b0;
   logic        m_done = 1'b0;
   logic        m_rdy  = 1'b0;
   int          m_n    = 0;
   int          m_len  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr = SEED;
         m_run  = 1'b0;
         m_done = 1'b0;
         m_rdy  = 1'b0;
         m_n    = 0;
         m_len  = 0;
      end else begin
         logic xf;
         logic bit0;
         logic fb;
         xf   = m_run && vld && o_rdy && !start;
         bit0 = m_lfsr[0];
         fb   = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
         m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
         if (start) begin
            m_len  = int'(len_in);
            m_n    = 0;
            m_run  = (len_in != 0);
            m_done = (len_in == 0);
            m_rdy  = 1'b0;
         end else if (m_run) begin
            if (xf) m_n++;
            if (m_n == m_len) begin
               m_run  = 1'b0;
               m_done = 1'b1;
               m_rdy  = 1'b0;
            end else begin
               m_rdy = !stall_en || bit0;
            end
         end else begin
            m_rdy = 1'b0;
         end
         #1;
         check("rdy", 64'(o_rdy), 64'(m_rdy));
         check("busy", 64'(o_busy), 64'(m_run));
         check("done", 64'(o_done), 64'(m_done));
      end
   end

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic start_run(input int n, input logic [7:0] first, input logic stall);
      start    = 1'b1;
      len_in   = COUNT_W'(n);
      exp_in   = first;
      stall_en = stall;
      vld      = 1'b0;
      p_exp0   = first;
      p_cnt    = 0;
      p_err    = 1'b0;
      p_idx    = '0;
      p_edata  = '0;
      p_eexp   = '0;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Compliant source: holds the beat until it is taken.
   task automatic send_beat(input logic [7:0] d, output int waited);
      logic taken;
      push_beat(d);
      vld    = 1'b1;
      data   = d;
      waited = 0;
      taken  = 1'b0;
      while (!taken && waited < 300) begin
         @(posedge clk);
         taken = o_rdy;
         waited++;
         @(negedge clk);
      end
      check("beat_accepted", 64'(taken), 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!o_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", 64'(o_done), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int total;
      int n;
      logic [7:0] first;
      logic [7:0] d;
      logic st;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdy",   64'(o_rdy),   64'd0);
      check("rst_busy",  64'(o_busy),  64'd0);
      check("rst_done",  64'(o_done),  64'd0);
      check("rst_beats", 64'(o_beats), 64'd0);
      check("rst_errs",  64'({o_err, o_err_idx, o_err_data, o_err_exp, o_proto_err}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Four back-to-back beats, then a fifth must stay pending
      start_run(4, 8'h10, 1'b0);
      total = 0;
      for (int i = 0; i < 4; i++) begin
         send_beat(8'h10 + 8'(i), w);
         total += w;
      end
      check("t1_cycles", 64'(total), 64'd5);
      vld  = 1'b1;
      data = 8'h14;
      repeat (3) @(negedge clk);
      check("t1_beats", 64'(o_beats), 64'd4);
      check("t1_done",  64'(o_done),  64'd1);
      check("t1_err",   64'(o_err),   64'd0);
      check("t1_rdy",   64'(o_rdy),   64'd0);
      vld = 1'b0;
      @(negedge clk);

      // Expected value wraps FF -> 00
      start_run(3, 8'hFE, 1'b0);
      send_beat(8'hFE, w);
      send_beat(8'hFF, w);
      send_beat(8'h00, w);
      vld = 1'b0;
      wait_done();
      check("t2_err",   64'(o_err),   64'd0);
      check("t2_beats", 64'(o_beats), 64'd3);

      // Two mismatches; only the first is captured
      start_run(5, 8'h00, 1'b0);
      send_beat(8'h00, w);
      send_beat(8'h01, w);
      send_beat(8'h07, w);
      send_beat(8'h03, w);
      send_beat(8'h09, w);
      vld = 1'b0;
      wait_done();
      check("t3_err",   64'(o_err),      64'd1);
      check("t3_idx",   64'(o_err_idx),  64'd2);
      check("t3_data",  64'(o_err_data), 64'h07);
      check("t3_exp",   64'(o_err_exp),  64'h02);
      check("t3_beats", 64'(o_beats),    64'd5);

      // Long run under pseudo-random backpressure, compliant source
      first = 8'($urandom);
      start_run(100, first, 1'b1);
      for (int i = 0; i < 100; i++) send_beat(first + 8'(i), w);
      vld = 1'b0;
      wait_done();
      check("t4_beats", 64'(o_beats),     64'd100);
      check("t4_proto", 64'(o_proto_err), 64'd0);
      check("t4_err",   64'(o_err),       64'd0);

      // Data changes while stalled; the next start clears the flag
      sb_en = 1'b0;
      start_run(10, 8'h05, 1'b1);
      vld  = 1'b1;
      data = 8'h05;
      @(negedge clk);
      check("t5_proto_before", 64'(o_proto_err), 64'd0);
      data = 8'h06;
      @(negedge clk);
      check("t5_proto_set", 64'(o_proto_err), 64'd1);
      vld = 1'b0;
      @(negedge clk);
      start_run(2, 8'h40, 1'b0);
      check("t5_proto_clr", 64'(o_proto_err), 64'd0);
      check("t5_beats_clr", 64'(o_beats),     64'd0);
      sb_en = 1'b1;
      send_beat(8'h40, w);
      send_beat(8'h41, w);
      vld = 1'b0;
      wait_done();
      check("t5_beats", 64'(o_beats), 64'd2);

      // Reset mid-run after three beats
      start_run(8, 8'h20, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(8'h20 + 8'(i), w);
      rst_n = 1'b0;
      #1;
      check("t6_rst_outs", 64'({o_rdy, o_busy, o_done, o_beats, o_err, o_err_idx,
                                o_err_data, o_err_exp, o_proto_err}), 64'd0);
      vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_sb_drained", 64'(sb_q.size()), 64'd0);
      @(negedge clk);
      start_run(2, 8'h33, 1'b0);
      send_beat(8'h33, w);
      send_beat(8'h34, w);
      vld = 1'b0;
      wait_done();
      check("t6_beats", 64'(o_beats), 64'd2);
      check("t6_err",   64'(o_err),   64'd0);

      // Randomized runs with occasional corrupted beats and idle gaps
      for (int r = 0; r < 8; r++) begin
         n     = int'($urandom_range(1, 30));
         first = 8'($urandom);
         st    = 1'($urandom);
         start_run(n, first, st);
         for (int i = 0; i < n; i++) begin
            d = first + 8'(i);
            if ($urandom_range(0, 7) == 0) d = 8'($urandom);
            send_beat(d, w);
            if ($urandom_range(0, 3) == 0) begin
               vld = 1'b0;
               @(negedge clk);
            end
         end
         vld = 1'b0;
         wait_done();
         check("rnd_beats", 64'(o_beats),     64'(n));
         check("rnd_err",   64'(o_err),       64'(p_err));
         check("rnd_proto", 64'(o_proto_err), 64'd0);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_sink.md
# stream_sink

Consumer end of the valid/ready stream interface used by `pipe_stage`. It drives `o_rdy` with optional pseudo-random backpressure, accepts a programmed number of beats, checks each against an incrementing expected sequence, and flags handshake-protocol violations by the upstream source. It sits at the output of a `pipe_stage` chain in `tb` and gives VPI/Lua scripts pass/fail status and counters.

## Interface
- `WIDTH`, 8, data width; must match the upstream `pipe_stage`.
- `COUNT_W`, 16, width of the beat-length, beat-count and error-index fields.
- `SEED`, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- `i_clk` in 1: sole clock; all logic on rising edge.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_data` in WIDTH: stream data.
- `i_vld` in 1: stream valid.
- `o_rdy` out 1: stream ready, registered.
- `i_start` in 1: one-cycle pulse; clears status and starts a run.
- `i_len` in COUNT_W: beats to accept; sampled on `i_start`.
- `i_expect` in WIDTH: expected first data value; sampled on `i_start`.
- `i_stall_en` in 1: 1 = pseudo-random backpressure, 0 = always ready in RUN.
- `o_busy` out 1: FSM in RUN.
- `o_done` out 1: FSM in DONE.
- `o_beats` out COUNT_W: beats accepted this run.
- `o_err` out 1: sticky data-mismatch flag.
- `o_err_idx` out COUNT_W: beat index of the first mismatch.
- `o_err_data` out WIDTH: received value at the first mismatch.
- `o_err_exp` out WIDTH: expected value at the first mismatch.
- `o_proto_err` out 1: sticky protocol-violation flag.

## Operation
- A transfer occurs on a rising edge where `i_vld && o_rdy`.
- FSM states:
  - IDLE: entered at reset; `o_rdy`=0.
  - RUN: beats are accepted.
  - DONE: `o_rdy`=0, `o_done`=1; left only by `i_start`.
- FSM transitions:
  - `i_start` in any state: load `i_len` and `i_expect`; clear `o_beats`, `o_err`, `o_err_*` and `o_proto_err`.
  - On `i_start`, go to DONE if `i_len`==0, otherwise RUN.
  - In RUN, a transfer with `o_beats+1 == len` goes to DONE.
- Checking, per transfer in RUN:
  - Compare `i_data` with `expect`.
  - Then `o_beats` += 1 and `expect` += 1, modulo 2^WIDTH (wraps FF→00).
  - On a mismatch while `o_err`=0: set `o_err` and capture `o_err_idx`=`o_beats` (pre-increment), `o_err_data` and `o_err_exp`.
  - Later mismatches set nothing further.
- Backpressure:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset to `SEED`.
  - Advances every cycle regardless of state.
  - In RUN, next `o_rdy` = `!i_stall_en | lfsr[0]`.
  - Next `o_rdy` is forced to 0 when the current cycle is the last transfer or the FSM is not RUN next cycle.
- Protocol check, RUN only:
  - Register `stalled = i_vld && !o_rdy` and `i_data`.
  - If `stalled` was set last cycle and now `!i_vld` or `i_data` changed, set `o_proto_err`.
- `i_start` coinciding with a transfer: the beat is consumed on the wire but not counted or checked; start takes priority.
- `o_beats` never exceeds `len`.

## Timing
- Reset values:
  - `o_rdy`=0, `o_busy`=0, `o_done`=0, `o_beats`=0.
  - `o_err`=0, `o_err_idx`=0, `o_err_data`=0, `o_err_exp`=0, `o_proto_err`=0.
  - FSM=IDLE, LFSR=`SEED`.
- `i_start` at edge N: `o_busy`=1 after edge N; earliest `o_rdy`=1 after edge N+1; first transfer at edge N+2.
- With `i_stall_en`=0, throughput is one beat per cycle from then on.
- Transfer at edge N: `o_beats`, `o_err*` and `o_proto_err` update after edge N.
- Last transfer at edge N: `o_rdy`=0 and `o_done`=1 after edge N. No extra beat is accepted.
- Reset assertion mid-run: all outputs return to reset values immediately (asynchronous); the run is abandoned.
- All outputs are registered; there is no combinational path from `i_vld` to `o_rdy`.

## Test plan
- `i_len`=4, `i_expect`=8'h10, stall off, source sends 10,11,12,13 back-to-back:
  - transfers at 4 consecutive edges, `o_beats`=4, `o_done`=1, `o_err`=0, `o_rdy`=0 afterwards;
  - a 5th offered beat stays pending.
- `i_len`=3, `i_expect`=8'hFE, source sends FE,FF,00 → wraps, `o_err`=0, `o_done`=1.
- `i_len`=5, `i_expect`=0, source sends 0,1,7,3,9 → `o_err`=1, `o_err_idx`=2, `o_err_data`=7, `o_err_exp`=2; the second mismatch does not overwrite; `o_beats`=5.
- Stall on, `i_len`=100, compliant source:
  - `o_rdy` follows LFSR bit 0 (compare to a model seeded with ACE1);
  - `o_beats`=100, `o_proto_err`=0.
- Stall on; source changes `i_data` 5→6 while `i_vld`=1 and `o_rdy`=0 → `o_proto_err`=1 after that edge; `i_start` clears it.
- Reset pulsed mid-run after 3 beats of `i_len`=8 → all outputs 0, FSM IDLE; a new `i_start` with `i_len`=2 completes normally.
